// File: rtl/password_entry.sv
// Player guess entry for the defuse game: debounced confirm, limited tries, seconds
// countdown on a two-digit scanned 7-segment display, sticky win/boom results.
module password_entry #(
  parameter int CLK_DIV    = 1000,
  parameter int TIME_LIMIT = 30,
  parameter int MAX_TRIES  = 3,
  parameter int DEB_CYCLES = 20,
  parameter int SCAN_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] psw,
  input  logic [6:0] sw,
  input  logic       confirm,
  output logic [6:0] LD,
  output logic [7:0] seg,
  output logic [7:0] cat,
  output logic [1:0] tries_left,
  output logic       busy,
  output logic       win,
  output logic       boom
);

  localparam int TW = $clog2(CLK_DIV + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_BOOM  = 3'd4
  } state_t;

  function automatic logic [7:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 8'h3F;
      4'd1:    font = 8'h06;
      4'd2:    font = 8'h5B;
      4'd3:    font = 8'h4F;
      4'd4:    font = 8'h66;
      4'd5:    font = 8'h6D;
      4'd6:    font = 8'h7D;
      4'd7:    font = 8'h07;
      4'd8:    font = 8'h7F;
      4'd9:    font = 8'h6F;
      default: font = 8'h00;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          start_q, start_d, start_prev_q, start_prev_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          stable_q, stable_d, press_q, press_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    sec_q, sec_d;
  logic [1:0]    tries_q, tries_d;
  logic [6:0]    guess_q, guess_d;
  logic          blink_q, blink_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          digit_q, digit_d;
  logic [6:0]    ld_q, ld_d;
  logic [7:0]    seg_q, seg_d, cat_q, cat_d;
  logic          busy_q, busy_d, win_q, win_d, boom_q, boom_d;
  logic          start_rise_s, tick_wrap_s, timeout_s;
  logic [7:0]    ones_s, tens_s;

  // Start edge detect plus confirm synchronizer and debouncer.
  always_comb begin
    start_d      = start;
    start_prev_d = start_q;
    start_rise_s = start_q & ~start_prev_q;
    sync1_d      = confirm;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    deb_cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
    press_d = stable_d & ~stable_q;
  end

  // Game FSM: countdown, guess latch, try accounting and registered status outputs.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    sec_d       = sec_q;
    tries_d     = tries_q;
    guess_d     = guess_q;
    blink_d     = blink_q;
    tick_wrap_s = (tick_q == TICK_LAST);
    timeout_s   = tick_wrap_s && (sec_q <= 8'd1);
    case (state_q)
      S_IDLE: begin
        if (start_rise_s) begin
          state_d = S_ENTRY;
          sec_d   = 8'(TIME_LIMIT);
          tries_d = 2'(MAX_TRIES);
          tick_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ENTRY: begin
        if (tick_wrap_s) begin
          tick_d = '0;
          sec_d  = (sec_q != 8'd0) ? sec_q - 8'd1 : 8'd0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
        // A timeout on the same cycle as a press takes priority.
        if (timeout_s) begin
          state_d = S_BOOM;
          sec_d   = 8'd0;
          blink_d = 1'b1;
        end else if (press_q) begin
          guess_d = sw;
          state_d = S_CHECK;
        end else begin
          state_d = S_ENTRY;
        end
      end
      S_CHECK: begin
        if (guess_q == psw) begin
          state_d = S_WIN;
        end else begin
          tries_d = (tries_q != 2'd0) ? tries_q - 2'd1 : 2'd0;
          if (tries_q <= 2'd1) begin
            state_d = S_BOOM;
            sec_d   = 8'd0;
            blink_d = 1'b1;
          end else begin
            state_d = S_ENTRY;
          end
        end
      end
      S_WIN: begin
        state_d = S_WIN;
      end
      S_BOOM: begin
        sec_d = 8'd0;
        if (tick_wrap_s) begin
          tick_d  = '0;
          blink_d = ~blink_q;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_ENTRY, S_CHECK: ld_d = sw;
      S_WIN:            ld_d = 7'h7F;
      S_BOOM:           ld_d = blink_d ? 7'h7F : 7'h00;
      default:          ld_d = 7'h00;
    endcase
    busy_d = (state_d == S_ENTRY) || (state_d == S_CHECK);
    win_d  = (state_d == S_WIN);
    boom_d = (state_d == S_BOOM);
  end

  // Two-digit display scan; the tens digit is blanked when zero except in BOOM.
  always_comb begin
    ones_s  = sec_q % 8'd10;
    tens_s  = sec_q / 8'd10;
    scan_d  = '0;
    digit_d = 1'b0;
    cat_d   = 8'hFF;
    seg_d   = 8'h00;
    if (state_q != S_IDLE) begin
      if (scan_q == SCAN_LAST) begin
        scan_d  = '0;
        digit_d = ~digit_q;
      end else begin
        scan_d  = scan_q + SW'(1);
        digit_d = digit_q;
      end
      if (digit_q) begin
        cat_d = 8'b1111_1101;
        seg_d = ((tens_s == 8'd0) && (state_q != S_BOOM)) ? 8'h00 : font(tens_s[3:0]);
      end else begin
        cat_d = 8'b1111_1110;
        seg_d = font(ones_s[3:0]);
      end
    end else begin
      cat_d = 8'hFF;
      seg_d = 8'h00;
    end
  end

  // State and output registers. start resets high so a level held through reset cannot rearm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b1;
      start_prev_q <= 1'b1;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_cnt_q    <= '0;
      stable_q     <= 1'b0;
      press_q      <= 1'b0;
      tick_q       <= '0;
      sec_q        <= 8'(TIME_LIMIT);
      tries_q      <= 2'(MAX_TRIES);
      guess_q      <= 7'h00;
      blink_q      <= 1'b0;
      scan_q       <= '0;
      digit_q      <= 1'b0;
      ld_q         <= 7'h00;
      seg_q        <= 8'h00;
      cat_q        <= 8'hFF;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      boom_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_cnt_q    <= deb_cnt_d;
      stable_q     <= stable_d;
      press_q      <= press_d;
      tick_q       <= tick_d;
      sec_q        <= sec_d;
      tries_q      <= tries_d;
      guess_q      <= guess_d;
      blink_q      <= blink_d;
      scan_q       <= scan_d;
      digit_q      <= digit_d;
      ld_q         <= ld_d;
      seg_q        <= seg_d;
      cat_q        <= cat_d;
      busy_q       <= busy_d;
      win_q        <= win_d;
      boom_q       <= boom_d;
    end
  end

  assign LD         = ld_q;
  assign seg        = seg_q;
  assign cat        = cat_q;
  assign tries_left = tries_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign boom       = boom_q;

endmodule
